// File: rtl/skid_pkg.sv
// Shared definitions for the two-entry AXI-Stream skid buffer.
package skid_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage : skid_pkg

// File: rtl/skid_reg.sv
// WIDTH-bit enable register with asynchronous active-low clear; holds one beat.
module skid_reg
  import skid_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule : skid_reg

// File: rtl/skid_buffer.sv
// Two-entry AXI-Stream skid buffer: OUT register feeds m_data, SKID catches the beat
// that arrives while downstream stalls. Every output comes straight from a flop.
module skid_buffer
  import skid_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  skid_state_e      state_q, state_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic             out_en, skid_en, out_from_skid;
  logic [WIDTH-1:0] out_d, skid_q;
  logic             s_fire, m_fire;

  assign s_fire = s_valid & s_ready_q;
  assign m_fire = m_valid_q & m_ready;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    out_en        = 1'b0;
    skid_en       = 1'b0;
    out_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (s_fire) begin
          out_en  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (s_fire && m_fire) begin
          out_en = 1'b1;
        end else if (s_fire) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (m_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (m_fire) begin
          out_en        = 1'b1;
          out_from_skid = 1'b1;
          state_d       = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign out_d = out_from_skid ? skid_q : s_data;

  // Handshake flags are registered copies of the next state, keeping outputs flop-driven.
  assign m_valid_d = (state_d != EMPTY);
  assign s_ready_d = (state_d != FULL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= EMPTY;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
    end
  end

  skid_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk  (clk),
    .rstn (rstn),
    .en   (out_en),
    .d    (out_d),
    .q    (m_data)
  );

  skid_reg #(.WIDTH(WIDTH)) u_skid_reg (
    .clk  (clk),
    .rstn (rstn),
    .en   (skid_en),
    .d    (s_data),
    .q    (skid_q)
  );

  assign m_valid = m_valid_q;
  assign s_ready = s_ready_q;

endmodule : skid_buffer

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: directed scenarios plus random packet traffic,
// all compared against a queue-based model of a two-beat FIFO.
module tb_skid_buffer;

  localparam int WIDTH    = 8;
  localparam int PKTS     = 100;
  localparam int PKT_LEN  = 10;
  localparam int TOTAL    = PKTS * PKT_LEN;
  localparam int BUDGET   = 60000;

  logic             clk     = 1'b0;
  logic             rstn    = 1'b0;
  logic [WIDTH-1:0] s_data  = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Model: beats currently held (front = on m_data), beats delivered, and whether
  // the first post-reset edge has happened yet.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] rx[$];
  logic [WIDTH-1:0] tx[$];
  bit               ready_en = 1'b0;

  skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " m_valid"}, 32'(m_valid), 32'(mq.size() > 0));
    check({tag, " s_ready"}, 32'(s_ready), 32'(ready_en && mq.size() < 2));
    if (mq.size() > 0) check({tag, " m_data"}, 32'(m_data), 32'(mq[0]));
    else if (!rstn)    check({tag, " m_data rst"}, 32'(m_data), 32'd0);
  endtask

  // One cycle: drive inputs, apply the FIFO rules at the edge, compare at the falling edge.
  task automatic step(input bit sv, input logic [WIDTH-1:0] sd, input bit mr, input string tag);
    bit sf, mf;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    @(posedge clk);
    if (rstn) begin
      sf = sv && ready_en && (mq.size() < 2);
      mf = mr && (mq.size() > 0);
      if (mf) rx.push_back(mq.pop_front());
      if (sf) mq.push_back(sd);
      ready_en = 1'b1;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    int rx_mark;
    int sent;
    int cycles;
    int bad;
    bit sv, mr, acc;

    // Reset and idle
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rstn = 1'b1;
    #1;
    check_outputs("release");
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, "idle");
    check("idle s_ready", 32'(s_ready), 32'd1);

    // Pass-through, 1-cycle latency, back-to-back
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, WIDTH'(i), 1'b1, "pass");
      check("pass data", 32'(m_data), 32'(i));
    end
    step(1'b0, '0, 1'b1, "pass drain");

    // Backpressure into FULL, then drain in order
    rx_mark = rx.size();
    step(1'b1, 8'hA5, 1'b0, "bp1");
    step(1'b1, 8'h5A, 1'b0, "bp2");
    check("bp full s_ready", 32'(s_ready), 32'd0);
    step(1'b1, 8'hFF, 1'b0, "bp hold");
    check("bp hold m_data", 32'(m_data), 32'hA5);
    step(1'b0, '0, 1'b1, "bp drain1");
    check("bp drain1 m_data", 32'(m_data), 32'h5A);
    check("bp drain1 s_ready", 32'(s_ready), 32'd1);
    step(1'b0, '0, 1'b1, "bp drain2");
    check("bp rx count", 32'(rx.size() - rx_mark), 32'd2);
    check("bp rx order", {16'd0, rx[rx_mark], rx[rx_mark+1]}, 32'hA55A);

    // Simultaneous fire in BUSY
    rx_mark = rx.size();
    step(1'b1, 8'h11, 1'b0, "sim load");
    step(1'b1, 8'h22, 1'b1, "sim fire");
    check("sim m_data", 32'(m_data), 32'h22);
    check("sim s_ready", 32'(s_ready), 32'd1);
    step(1'b0, '0, 1'b1, "sim drain");
    check("sim rx count", 32'(rx.size() - rx_mark), 32'd2);

    // Random packet traffic
    rx.delete();
    for (int i = 0; i < TOTAL; i++) tx.push_back(WIDTH'($urandom));
    sent   = 0;
    cycles = 0;
    while ((sent < TOTAL || mq.size() > 0) && cycles < BUDGET) begin
      sv  = (sent < TOTAL) && ($urandom_range(9) == 0);
      mr  = (sent < TOTAL / 2) ? 1'b1 : ($urandom_range(9) == 0);
      acc = sv && ready_en && (mq.size() < 2);
      step(sv, sv ? tx[sent] : WIDTH'($urandom), mr, "rand");
      if (acc) sent++;
      cycles++;
    end
    check("rand timeout", 32'(cycles < BUDGET), 32'd1);
    check("rand rx count", 32'(rx.size()), 32'(TOTAL));
    for (int p = 0; p < PKTS; p++) begin
      bad = 0;
      for (int b = 0; b < PKT_LEN; b++) begin
        int k = p * PKT_LEN + b;
        if (k >= rx.size() || rx[k] !== tx[k]) bad++;
      end
      check($sformatf("pkt%0d bad bytes", p), 32'(bad), 32'd0);
    end

    // Asynchronous reset while FULL
    step(1'b1, 8'hC1, 1'b0, "mr load1");
    step(1'b1, 8'hC2, 1'b0, "mr load2");
    check("mr full s_ready", 32'(s_ready), 32'd0);
    #2;
    rstn = 1'b0;
    mq.delete();
    ready_en = 1'b0;
    #1;
    check_outputs("mr async");
    step(1'b1, 8'h77, 1'b1, "mr held");
    rstn = 1'b1;
    #1;
    check_outputs("mr release");
    step(1'b0, '0, 1'b0, "mr idle");
    rx_mark = rx.size();
    step(1'b1, 8'h3C, 1'b1, "mr new");
    check("mr new m_data", 32'(m_data), 32'h3C);
    step(1'b0, '0, 1'b1, "mr drain");
    check("mr rx count", 32'(rx.size() - rx_mark), 32'd1);
    check("mr rx data", 32'(rx[rx.size()-1]), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_skid_buffer
